seq_fsm: RTL and testbench

SEQ_FSM -- requirements
Module: seq_fsm

---
 rtl/seq_fsm.sv | 83 ++++++++
 tb/tb_seq_fsm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_fsm.sv
// seq_fsm: debounced two-button sequence detector (AB/AA/BB) with timeout and hold timers.
module seq_fsm #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int TIMEOUT_TICKS  = 50,
  parameter int HOLD_TICKS     = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_mf,
  input  logic       btn_a,
  input  logic       btn_b,
  output logic [1:0] state,
  output logic       seq_valid
);
  localparam int DW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS > HOLD_TICKS ? TIMEOUT_TICKS : HOLD_TICKS) + 1;
  typedef enum logic [2:0] {IDLE, GOT_A, GOT_B, OUT_AB, OUT_AA, OUT_BB} st_t;
  logic [1:0] raw, ev;
  assign raw = {btn_b, btn_a};
  for (genvar b = 0; b < 2; b++) begin : g_db
    logic s1_q, s2_q, deb_q, deb_p_q;
    logic [DW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        deb_q   <= 1'b0;
        deb_p_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        s1_q    <= raw[b];
        s2_q    <= s1_q;
        deb_p_q <= deb_q;
        if (s2_q == deb_q) cnt_q <= '0;
        else if (tick_mf) begin
          if (cnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
            deb_q <= s2_q;
            cnt_q <= '0;
          end else if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
      end
    // Only rising debounced edges are events.
    assign ev[b] = deb_q & ~deb_p_q;
  end
  st_t st_q, st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [1:0] state_q, state_d;
  logic valid_q, valid_d, ev_a, ev_b, both, tmo, hld;
  always_comb begin
    ev_a = ev[0] & ~ev[1];
    ev_b = ev[1] & ~ev[0];
    both = ev[0] & ev[1];
    tmo  = tick_mf && tmr_q == TW'(TIMEOUT_TICKS - 1);
    hld  = tick_mf && tmr_q == TW'(HOLD_TICKS - 1);
    st_d = IDLE;
    case (st_q)
      IDLE:   st_d = both ? IDLE : ev_a ? GOT_A : ev_b ? GOT_B : IDLE;
      GOT_A:  st_d = both ? IDLE : ev_a ? OUT_AA : ev_b ? OUT_AB : tmo ? IDLE : GOT_A;
      GOT_B:  st_d = both ? IDLE : ev_b ? OUT_BB : ev_a ? GOT_A : tmo ? IDLE : GOT_B;
      OUT_AB, OUT_AA, OUT_BB: st_d = hld ? IDLE : st_q;
      default: st_d = IDLE;
    endcase
    // Any state change (including the GOT_B -> GOT_A restart) restarts the timer.
    tmr_d   = (st_d != st_q || st_q == IDLE) ? '0 :
              (tick_mf && tmr_q != '1) ? tmr_q + 1'b1 : tmr_q;
    state_d = st_d == OUT_AB ? 2'b01 : st_d == OUT_AA ? 2'b10 : st_d == OUT_BB ? 2'b11 : 2'b00;
    valid_d = (st_q == GOT_A || st_q == GOT_B) && state_d != 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q    <= IDLE;
      tmr_q   <= '0;
      state_q <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      tmr_q   <= tmr_d;
      state_q <= state_d;
      valid_q <= valid_d;
    end
  assign state     = state_q;
  assign seq_valid = valid_q;
endmodule

// File: tb/tb_seq_fsm.sv
// tb_seq_fsm: directed self-checking bench for seq_fsm with DEBOUNCE=2, TIMEOUT=5, HOLD=3, tick every 4 clk.
module tb_seq_fsm;
  logic clk = 1'b0, rst_n = 1'b0, tick_mf = 1'b0, btn_a = 1'b0, btn_b = 1'b0;
  logic [1:0] state;
  logic seq_valid;
  int checks = 0, errors = 0, nval = 0, nv = 0;
  seq_fsm #(.DEBOUNCE_TICKS(2), .TIMEOUT_TICKS(5), .HOLD_TICKS(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick_mf(tick_mf), .btn_a(btn_a), .btn_b(btn_b),
    .state(state), .seq_valid(seq_valid)
  );
  always #5 clk = ~clk;
  // tick_mf changes shortly after a rising edge so it is stable at every negedge.
  initial begin : tick_gen
    int t;
    t = 0;
    forever begin
      @(posedge clk);
      #2;
      tick_mf = (t == 3);
      t = (t + 1) % 4;
    end
  end
  initial forever begin
    @(negedge clk);
    if (seq_valid === 1'b1) nval++;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic align();
    while (!tick_mf) @(negedge clk);
  endtask
  task automatic press(input logic a, input logic b);
    align();
    btn_a = a;
    btn_b = b;
    repeat (8) @(negedge clk);
    btn_a = 1'b0;
    btn_b = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (state !== 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, state, 2'b00);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", state, 2'b00);
    chk("rst_valid", seq_valid, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    press(1, 0);
    chk("ab_gota", state, 2'b00);
    press(0, 1);
    chk("ab_out", state, 2'b01);
    chk("ab_valid", nval, 1);
    repeat (4) @(negedge clk);
    chk("ab_hold_last", state, 2'b01);
    @(negedge clk);
    chk("ab_hold_exit", state, 2'b00);
    press(0, 1);
    press(0, 1);
    chk("bb_out", state, 2'b11);
    chk("bb_valid", nval, 2);
    wait_idle("bb_idle");
    press(1, 0);
    press(1, 0);
    chk("aa_out", state, 2'b10);
    chk("aa_valid", nval, 3);
    wait_idle("aa_idle");
    press(0, 1);
    press(1, 0);
    press(0, 1);
    chk("bab_out", state, 2'b01);
    chk("bab_valid", nval, 4);
    wait_idle("bab_idle");
    press(1, 0);
    repeat (4) @(negedge clk);
    press(0, 1);
    chk("tmo_gotb", state, 2'b00);
    press(0, 1);
    chk("tmo_bb", state, 2'b11);
    chk("tmo_valid", nval, 5);
    wait_idle("tmo_idle");
    press(1, 0);
    repeat (20) @(negedge clk);
    chk("tmo2_idle", state, 2'b00);
    chk("tmo2_novalid", nval, 5);
    press(1, 0);
    chk("tmo2_gota", state, 2'b00);
    press(0, 1);
    chk("tmo2_ab", state, 2'b01);
    chk("tmo2_valid", nval, 6);
    wait_idle("tmo2_exit");
    align();
    btn_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn_a = ~btn_a;
    end
    repeat (10) @(negedge clk);
    btn_a = 1'b0;
    press(0, 1);
    chk("bounce_ab", state, 2'b01);
    chk("bounce_valid", nval, 7);
    wait_idle("bounce_idle");
    align();
    btn_a = 1'b1;
    repeat (5) @(negedge clk);
    btn_a = 1'b0;
    repeat (11) @(negedge clk);
    press(0, 1);
    press(0, 1);
    chk("glitch_bb", state, 2'b11);
    chk("glitch_valid", nval, 8);
    wait_idle("glitch_idle");
    press(1, 0);
    press(1, 1);
    chk("simul_idle", state, 2'b00);
    press(0, 1);
    press(0, 1);
    chk("simul_bb", state, 2'b11);
    chk("simul_valid", nval, 9);
    wait_idle("simul_exit");
    press(1, 0);
    align();
    btn_b = 1'b1;
    repeat (4) @(negedge clk);
    btn_a = 1'b1;
    repeat (4) @(negedge clk);
    btn_b = 1'b0;
    repeat (4) @(negedge clk);
    btn_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("ign_hold", state, 2'b01);
    repeat (4) @(negedge clk);
    chk("ign_hold_last", state, 2'b01);
    @(negedge clk);
    chk("ign_exit", state, 2'b00);
    chk("ign_valid", nval, 10);
    press(0, 1);
    press(0, 1);
    chk("ign_then_bb", state, 2'b11);
    wait_idle("ign_idle");
    press(1, 0);
    btn_a = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_pre_aa", state, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_state", state, 2'b00);
    chk("rst_async_valid", seq_valid, 1'b0);
    repeat (3) @(negedge clk);
    nv = nval;
    chk("rst_pre_valid", nv, 12);
    align();
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    chk("rst_rel_state", state, 2'b00);
    chk("rst_rel_novalid", nval, nv);
    btn_a = 1'b0;
    press(0, 1);
    chk("rst_gota_ab", state, 2'b01);
    chk("rst_final_valid", nval, nv + 1);
    wait_idle("final_idle");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
